// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state encoding,
// response tag encoding and the default starvation limit.
package imem_arbiter_pkg;

  // Default number of back-to-back fetch grants allowed while a side
  // request is waiting.
  localparam int unsigned MAX_RUN_DEFAULT = 8;
  localparam int unsigned RUN_CNT_W       = 4;

  typedef enum logic [0:0] {
    ARB        = 1'b0,
    WR_RECOVER = 1'b1
  } arb_state_t;

  // Records which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_SIDE  = 2'd2
  } resp_tag_t;

endpackage

// File: rtl/imem_rr_counter.sv
// Saturating starvation counter.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset (clears count)
//   inc  - increment request (ignored once saturated)
//   clr  - clear request (takes precedence over inc)
//   cnt  - current count
//   sat  - count has reached MAX
module imem_rr_counter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = MAX_RUN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [RUN_CNT_W-1:0] cnt,
  output logic                 sat
);

  localparam logic [RUN_CNT_W-1:0] MAX_CNT = RUN_CNT_W'(MAX);

  assign sat = (cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter between the fetch stage and a side
// (loader/debug) port. Fetch normally has priority; a saturating run
// counter forces a side grant after MAX_RUN consecutive fetch grants
// while the side port is waiting. A side write is followed by one
// dead cycle (WR_RECOVER). Read data is routed back one cycle after
// the grant using a registered response tag.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   f_req, f_addr                 - fetch request / address
//   f_gnt, f_valid, f_data        - fetch grant, read response
//   s_req, s_we, s_addr, s_wdata  - side request
//   s_gnt, s_valid, s_rdata       - side grant, read response
//   m_en, m_we, m_addr, m_wdata   - memory command
//   m_rdata                       - memory read data (one cycle latency)
//   fetch_stall                   - registered: fetch was refused last cycle
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_RUN = MAX_RUN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_valid,
  output logic [31:0] f_data,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [31:0] s_addr,
  input  logic [31:0] s_wdata,
  output logic        s_gnt,
  output logic        s_valid,
  output logic [31:0] s_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        fetch_stall
);

  arb_state_t           state;
  resp_tag_t            tag;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 run_sat;

  imem_rr_counter #(
    .MAX (MAX_RUN)
  ) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .inc (f_gnt && s_req),
    .clr (s_gnt || !s_req),
    .cnt (run_cnt),
    .sat (run_sat)
  );

  // Grant decision. Nothing is granted while reset is asserted or during
  // the write-recovery cycle.
  always_comb begin
    f_gnt = 1'b0;
    s_gnt = 1'b0;
    if (rst && state == ARB) begin
      if (s_req && (!f_req || run_sat)) begin
        s_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = f_gnt || s_gnt;
    m_we    = s_gnt && s_we;
    m_addr  = '0;
    m_wdata = '0;
    if (f_gnt) begin
      m_addr = f_addr;
    end else if (s_gnt) begin
      m_addr  = s_addr;
      m_wdata = s_wdata;
    end
  end

  // Responses are also masked by rst so a read that is in flight when
  // reset is asserted never produces a valid pulse.
  always_comb begin
    f_valid = rst && (tag == TAG_FETCH);
    s_valid = rst && (tag == TAG_SIDE);
    f_data  = f_valid ? m_rdata : '0;
    s_rdata = s_valid ? m_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ARB;
      tag         <= TAG_NONE;
      fetch_stall <= 1'b0;
    end else begin
      fetch_stall <= f_req && !f_gnt;

      if (f_gnt) begin
        tag <= TAG_FETCH;
      end else if (s_gnt && !s_we) begin
        tag <= TAG_SIDE;
      end else begin
        tag <= TAG_NONE;
      end

      unique case (state)
        ARB:        state <= (s_gnt && s_we) ? WR_RECOVER : ARB;
        WR_RECOVER: state <= ARB;
        default:    state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_valid;
  logic [31:0] f_data;
  logic        s_req;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic        s_valid;
  logic [31:0] s_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        fetch_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_arbiter #(
    .MAX_RUN (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .f_req       (f_req),
    .f_addr      (f_addr),
    .f_gnt       (f_gnt),
    .f_valid     (f_valid),
    .f_data      (f_data),
    .s_req       (s_req),
    .s_we        (s_we),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_gnt       (s_gnt),
    .s_valid     (s_valid),
    .s_rdata     (s_rdata),
    .m_en        (m_en),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_rdata     (m_rdata),
    .fetch_stall (fetch_stall)
  );

  // Inputs change 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; f_req = 1'b1; f_addr = 32'h0; s_req = 1'b0; s_we = 1'b0;
    s_addr = 32'h0; s_wdata = 32'h0; m_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      #1;
      checks++; if (f_gnt !== 1'b0) begin failures++; $display("FAIL reset_f_gnt[%0d]: got %0b want 0", i, f_gnt); end
      checks++; if (m_en !== 1'b0) begin failures++; $display("FAIL reset_m_en[%0d]: got %0b want 0", i, m_en); end
      checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL reset_f_valid[%0d]: got %0b want 0", i, f_valid); end
      checks++; if (fetch_stall !== 1'b0) begin failures++; $display("FAIL reset_fetch_stall[%0d]: got %0b want 0", i, fetch_stall); end
      checks++; if (f_data !== 32'h0) begin failures++; $display("FAIL reset_f_data[%0d]: got %h want 0", i, f_data); end
    end
    cycle();
    rst = 1'b1; f_req = 1'b0;
  endtask

  task automatic test_fetch_only();
    cycle();
    f_req = 1'b1; f_addr = 32'h100;
    #1;
    checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL fetch_gnt: got %0b want 1", f_gnt); end
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0) begin failures++; $display("FAIL fetch_m_en_we: got %0b%0b want 10", m_en, m_we); end
    checks++; if (m_addr !== 32'h100) begin failures++; $display("FAIL fetch_m_addr: got %h want 00000100", m_addr); end
    checks++; if (s_gnt !== 1'b0) begin failures++; $display("FAIL fetch_s_gnt: got %0b want 0", s_gnt); end
    cycle();
    f_req = 1'b0; m_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (f_valid !== 1'b1) begin failures++; $display("FAIL fetch_valid: got %0b want 1", f_valid); end
    checks++; if (f_data !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_data: got %h want deadbeef", f_data); end
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL fetch_s_valid: got %0b want 0", s_valid); end
    checks++; if (fetch_stall !== 1'b0) begin failures++; $display("FAIL fetch_no_stall: got %0b want 0", fetch_stall); end
    cycle();
    #1;
    checks++; if (f_valid !== 1'b0 || f_data !== 32'h0) begin failures++; $display("FAIL fetch_idle: got valid=%0b data=%h want 0/0", f_valid, f_data); end
  endtask

  task automatic test_starvation();
    int fetch_grants;
    fetch_grants = 0;
    cycle();
    f_req = 1'b1; f_addr = 32'h200; s_req = 1'b1; s_we = 1'b0; s_addr = 32'h40;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (f_gnt === 1'b1 && s_gnt === 1'b0) fetch_grants++;
      cycle();
    end
    checks++; if (fetch_grants != 8) begin failures++; $display("FAIL starve_fetch_grants: got %0d want 8", fetch_grants); end
    #1;
    checks++; if (s_gnt !== 1'b1 || f_gnt !== 1'b0) begin failures++; $display("FAIL starve_side_gnt: got s=%0b f=%0b want s=1 f=0", s_gnt, f_gnt); end
    checks++; if (m_addr !== 32'h40) begin failures++; $display("FAIL starve_m_addr: got %h want 00000040", m_addr); end
    cycle();
    s_req = 1'b0; m_rdata = 32'hCAFE0001;
    #1;
    checks++; if (s_valid !== 1'b1 || s_rdata !== 32'hCAFE0001) begin failures++; $display("FAIL starve_s_rdata: got v=%0b d=%h want 1/cafe0001", s_valid, s_rdata); end
    checks++; if (f_valid !== 1'b0) begin failures++; $display("FAIL starve_f_valid: got %0b want 0", f_valid); end
    checks++; if (fetch_stall !== 1'b1) begin failures++; $display("FAIL starve_fetch_stall: got %0b want 1", fetch_stall); end
    checks++; if (f_gnt !== 1'b1) begin failures++; $display("FAIL starve_fetch_resume: got %0b want 1", f_gnt); end
    cycle();
    f_req = 1'b0; m_rdata = 32'h0BADF00D;
    #1;
    checks++; if (f_valid !== 1'b1 || s_valid !== 1'b0 || fetch_stall !== 1'b0) begin failures++; $display("FAIL starve_after: got fv=%0b sv=%0b st=%0b want 1/0/0", f_valid, s_valid, fetch_stall); end
  endtask

  task automatic test_side_immediate();
    cycle();
    f_req = 1'b1; s_req = 1'b1; s_we = 1'b0; s_addr = 32'h80;
    for (int i = 0; i < 3; i++) cycle();
    f_req = 1'b0;
    #1;
    checks++; if (s_gnt !== 1'b1 || f_gnt !== 1'b0) begin failures++; $display("FAIL side_immediate: got s=%0b f=%0b want s=1 f=0", s_gnt, f_gnt); end
    cycle();
    s_req = 1'b0;
  endtask

  task automatic test_side_write();
    cycle();
    f_req = 1'b0; s_req = 1'b1; s_we = 1'b1; s_addr = 32'h20; s_wdata = 32'h12345678;
    #1;
    checks++; if (s_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b1) begin failures++; $display("FAIL wr_gnt: got gnt=%0b en=%0b we=%0b want 1/1/1", s_gnt, m_en, m_we); end
    checks++; if (m_wdata !== 32'h12345678 || m_addr !== 32'h20) begin failures++; $display("FAIL wr_cmd: got a=%h d=%h want 00000020/12345678", m_addr, m_wdata); end
    cycle();
    s_req = 1'b0; s_we = 1'b0; f_req = 1'b1; f_addr = 32'h300; m_rdata = 32'h77777777;
    #1;
    checks++; if (f_gnt !== 1'b0 || s_gnt !== 1'b0 || m_en !== 1'b0) begin failures++; $display("FAIL wr_recover: got f=%0b s=%0b en=%0b want 0/0/0", f_gnt, s_gnt, m_en); end
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL wr_s_valid: got %0b want 0", s_valid); end
    cycle();
    #1;
    checks++; if (f_gnt !== 1'b1 || fetch_stall !== 1'b1 || s_valid !== 1'b0) begin failures++; $display("FAIL wr_back_to_arb: got f=%0b st=%0b sv=%0b want 1/1/0", f_gnt, fetch_stall, s_valid); end
    cycle();
    f_req = 1'b0;
    #1;
    checks++; if (f_valid !== 1'b1 || fetch_stall !== 1'b0) begin failures++; $display("FAIL wr_fetch_valid: got fv=%0b st=%0b want 1/0", f_valid, fetch_stall); end
  endtask

  task automatic test_mid_reset();
    cycle();
    f_req = 1'b0; s_req = 1'b1; s_we = 1'b0; s_addr = 32'h44;
    #1;
    checks++; if (s_gnt !== 1'b1) begin failures++; $display("FAIL mrst_side_gnt: got %0b want 1", s_gnt); end
    cycle();
    rst = 1'b0; f_req = 1'b1; m_rdata = 32'h55AA55AA;
    #1;
    checks++; if (s_valid !== 1'b0 || s_rdata !== 32'h0) begin failures++; $display("FAIL mrst_discard: got v=%0b d=%h want 0/0", s_valid, s_rdata); end
    checks++; if (f_gnt !== 1'b0 || s_gnt !== 1'b0 || m_en !== 1'b0) begin failures++; $display("FAIL mrst_no_gnt: got f=%0b s=%0b en=%0b want 0/0/0", f_gnt, s_gnt, m_en); end
    cycle();
    rst = 1'b1;
    #1;
    checks++; if (s_valid !== 1'b0 || fetch_stall !== 1'b0) begin failures++; $display("FAIL mrst_after: got sv=%0b st=%0b want 0/0", s_valid, fetch_stall); end
    checks++; if (f_gnt !== 1'b1 || s_gnt !== 1'b0) begin failures++; $display("FAIL mrst_fetch_first: got f=%0b s=%0b want 1/0", f_gnt, s_gnt); end
    // Saturate the counter, then reset with both requests held: fetch must
    // win afterwards, which only happens if reset cleared the count.
    for (int i = 0; i < 8; i++) cycle();
    #1;
    checks++; if (s_gnt !== 1'b1) begin failures++; $display("FAIL mrst_sat: got s=%0b want 1", s_gnt); end
    cycle();
    for (int i = 0; i < 8; i++) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    checks++; if (f_gnt !== 1'b1 || s_gnt !== 1'b0) begin failures++; $display("FAIL mrst_cnt_cleared: got f=%0b s=%0b want 1/0", f_gnt, s_gnt); end
    cycle();
    f_req = 1'b0; s_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_starvation();
    test_side_immediate();
    test_side_write();
    test_mid_reset();
    cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
